// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: operand capture and display sequencer for the 4-bit ripple adder.
// The button is synchronized and debounced; two operands are taken from the
// switches on successive presses. After the adder settles, the 5-bit sum is
// latched and split into decimal digits for the digit-to-segment coder.
module add_seq_ctrl #(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int CNT_W           = 18,
  parameter int SETTLE_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] num,
  input  logic       button,
  input  logic [3:0] add_sum,
  input  logic       add_cout,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic [3:0] disp_tens,
  output logic [3:0] disp_ones,
  output logic       tens_blank,
  output logic [1:0] phase,
  output logic       result_valid
);

  // Settle counter runs 0..SETTLE_CYCLES-1; keep at least one bit.
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    SETTLE = 2'd2,
    SHOW   = 2'd3
  } state_t;

  // Decimal tens digit of a value in 0..31 (operands and sums stay below 31).
  function automatic logic [3:0] tens_of(input logic [4:0] v);
    if (v >= 5'd30)      return 4'd3;
    else if (v >= 5'd20) return 4'd2;
    else if (v >= 5'd10) return 4'd1;
    else                 return 4'd0;
  endfunction

  // Decimal ones digit: subtract ten times the tens digit.
  function automatic logic [3:0] ones_of(input logic [4:0] v);
    logic [4:0] rem;
    rem = v - ({1'b0, tens_of(v)} * 5'd10);
    return rem[3:0];
  endfunction

  logic [3:0]       num_s1_reg, num_s2_reg;
  logic             btn_s1_reg, btn_s2_reg;
  logic             db_level_reg;
  logic [CNT_W-1:0] db_cnt_reg;
  logic             press_reg;
  logic             db_flip;

  state_t           state_reg;
  logic [SET_W-1:0] settle_cnt_reg;
  logic [3:0]       op_a_reg, op_b_reg;
  logic [3:0]       disp_tens_reg, disp_ones_reg;
  logic             tens_blank_reg;
  logic             result_valid_reg;

  logic [4:0]       live_val, res_val;
  logic [3:0]       live_tens, live_ones, res_tens, res_ones;

  assign live_val  = {1'b0, num_s2_reg};
  assign res_val   = {add_cout, add_sum};
  assign live_tens = tens_of(live_val);
  assign live_ones = ones_of(live_val);
  assign res_tens  = tens_of(res_val);
  assign res_ones  = ones_of(res_val);

  // Debounced level flips once the synchronized level has disagreed for DEBOUNCE_CYCLES cycles.
  assign db_flip = (btn_s2_reg != db_level_reg) &&
                   (db_cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1));

  // Two-flop synchronizers for the asynchronous switches and button.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_s1_reg <= 4'd0;
      num_s2_reg <= 4'd0;
      btn_s1_reg <= 1'b1;
      btn_s2_reg <= 1'b1;
    end else begin
      num_s1_reg <= num;
      num_s2_reg <= num_s1_reg;
      btn_s1_reg <= button;
      btn_s2_reg <= btn_s1_reg;
    end
  end

  // Debounce counter and one-cycle press pulse on the debounced high->low flip.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_level_reg <= 1'b1;
      db_cnt_reg   <= '0;
      press_reg    <= 1'b0;
    end else begin
      press_reg <= db_flip && db_level_reg;
      if (btn_s2_reg == db_level_reg) begin
        db_cnt_reg <= '0;
      end else if (db_flip) begin
        db_cnt_reg   <= '0;
        db_level_reg <= ~db_level_reg;
      end else begin
        db_cnt_reg <= db_cnt_reg + 1'b1;
      end
    end
  end

  // Sequencer FSM with registered operand and display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= LOAD_A;
      settle_cnt_reg   <= '0;
      op_a_reg         <= 4'd0;
      op_b_reg         <= 4'd0;
      disp_tens_reg    <= 4'd0;
      disp_ones_reg    <= 4'd0;
      tens_blank_reg   <= 1'b1;
      result_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        LOAD_A: begin
          disp_tens_reg  <= live_tens;
          disp_ones_reg  <= live_ones;
          tens_blank_reg <= (live_tens == 4'd0);
          if (press_reg) begin
            op_a_reg  <= num_s2_reg;
            state_reg <= LOAD_B;
          end
        end
        LOAD_B: begin
          disp_tens_reg  <= live_tens;
          disp_ones_reg  <= live_ones;
          tens_blank_reg <= (live_tens == 4'd0);
          if (press_reg) begin
            op_b_reg       <= num_s2_reg;
            settle_cnt_reg <= '0;
            state_reg      <= SETTLE;
          end
        end
        SETTLE: begin
          // Presses here are dropped; the display holds until the sum is taken.
          if (settle_cnt_reg == SET_W'(SETTLE_CYCLES - 1)) begin
            disp_tens_reg    <= res_tens;
            disp_ones_reg    <= res_ones;
            tens_blank_reg   <= (res_tens == 4'd0);
            result_valid_reg <= 1'b1;
            state_reg        <= SHOW;
          end else begin
            settle_cnt_reg <= settle_cnt_reg + 1'b1;
          end
        end
        SHOW: begin
          if (press_reg) begin
            result_valid_reg <= 1'b0;
            state_reg        <= LOAD_A;
          end
        end
        default: state_reg <= LOAD_A;
      endcase
    end
  end

  assign op_a         = op_a_reg;
  assign op_b         = op_b_reg;
  assign disp_tens    = disp_tens_reg;
  assign disp_ones    = disp_ones_reg;
  assign tens_blank   = tens_blank_reg;
  assign phase        = state_reg;
  assign result_valid = result_valid_reg;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb_add_seq_ctrl: table-driven and randomized checks of the adder sequencer
// against a transaction-level model of the press/capture/display behaviour.
module tb_add_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] num;
  logic       button;
  logic [3:0] add_sum;
  logic       add_cout;
  logic [3:0] op_a, op_b, disp_tens, disp_ones;
  logic       tens_blank, result_valid;
  logic [1:0] phase;

  add_seq_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(18),
    .SETTLE_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst), .num(num), .button(button),
    .add_sum(add_sum), .add_cout(add_cout),
    .op_a(op_a), .op_b(op_b), .disp_tens(disp_tens), .disp_ones(disp_ones),
    .tens_blank(tens_blank), .phase(phase), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  // Behavioural ripple adder.
  assign {add_cout, add_sum} = {1'b0, op_a} + {1'b0, op_b};

  int tests = 0;
  int fails = 0;

  // Transaction-level model: phase number, captured operands, latched sum.
  int m_phase = 0;
  int m_a = 0;
  int m_b = 0;
  int m_r = 0;

  int ph_hist[0:127];
  int rv_hist[0:127];
  int n_hist = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    int tens;
    int ones;
    int blank;
  } vec_t;

  typedef struct {
    logic [3:0] n;
    int tens;
    int ones;
    int blank;
  } sweep_t;

  vec_t   vecs[6];
  sweep_t sweeps[4];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_press(input int v);
    case (m_phase)
      0: begin m_a = v; m_phase = 1; end
      1: begin m_b = v; m_r = m_a + m_b; m_phase = 3; end
      default: m_phase = 0;
    endcase
  endtask

  // One press transaction: optional contact bounce, steady low for 'hold'
  // cycles (phase/result_valid recorded each cycle), then a clean release.
  task automatic press(input logic [3:0] v, input bit bounce, input int hold);
    num = v;
    step(4);
    if (bounce) begin
      for (int i = 0; i < 5; i++) begin
        button = 1'b0; step(2);
        button = 1'b1; step(2);
      end
    end
    ph_hist[0] = int'(phase);
    rv_hist[0] = int'(result_valid);
    n_hist = 1;
    button = 1'b0;
    for (int i = 0; i < hold; i++) begin
      step(1);
      ph_hist[n_hist] = int'(phase);
      rv_hist[n_hist] = int'(result_valid);
      n_hist++;
    end
    button = 1'b1;
    step(12);
    model_press(int'(v));
    $display("[TB] press num=%0d bounce=%0d -> phase=%0d op_a=%0d op_b=%0d disp=%0d%0d rv=%0d",
             v, bounce, phase, op_a, op_b, disp_tens, disp_ones, result_valid);
  endtask

  function automatic int count_changes();
    int c = 0;
    for (int i = 1; i < n_hist; i++)
      if (ph_hist[i] != ph_hist[i-1]) c++;
    return c;
  endfunction

  // result_valid must rise exactly two cycles after SETTLE is entered.
  task automatic check_settle(input string tag);
    int idx = -1;
    for (int i = 0; i < n_hist; i++)
      if (idx < 0 && ph_hist[i] == 2) idx = i;
    if (idx < 0 || idx + 2 >= n_hist) begin
      tests++;
      fails++;
      $display("FAIL %s.settle_seen: got no SETTLE window, expected phase 2", tag);
    end else begin
      check({tag, ".rv_at_settle"}, rv_hist[idx], 0);
      check({tag, ".rv_settle+1"}, rv_hist[idx+1], 0);
      check({tag, ".rv_settle+2"}, rv_hist[idx+2], 1);
      check({tag, ".phase_settle+2"}, ph_hist[idx+2], 3);
    end
  endtask

  task automatic check_all(input string tag);
    int val;
    val = (m_phase == 3) ? m_r : int'(num);
    check({tag, ".phase"}, int'(phase), m_phase);
    check({tag, ".op_a"}, int'(op_a), m_a);
    check({tag, ".op_b"}, int'(op_b), m_b);
    check({tag, ".rv"}, int'(result_valid), (m_phase == 3) ? 1 : 0);
    check({tag, ".tens"}, int'(disp_tens), val / 10);
    check({tag, ".ones"}, int'(disp_ones), val % 10);
    check({tag, ".blank"}, int'(tens_blank), (val / 10 == 0) ? 1 : 0);
  endtask

  initial begin
    bit found;

    vecs[0] = '{a: 4'd3,  b: 4'd4,  tens: 0, ones: 7, blank: 1};
    vecs[1] = '{a: 4'd15, b: 4'd15, tens: 3, ones: 0, blank: 0};
    vecs[2] = '{a: 4'd9,  b: 4'd1,  tens: 1, ones: 0, blank: 0};
    vecs[3] = '{a: 4'd0,  b: 4'd0,  tens: 0, ones: 0, blank: 1};
    vecs[4] = '{a: 4'd8,  b: 4'd9,  tens: 1, ones: 7, blank: 0};
    vecs[5] = '{a: 4'd12, b: 4'd13, tens: 2, ones: 5, blank: 0};

    sweeps[0] = '{n: 4'd9,  tens: 0, ones: 9, blank: 1};
    sweeps[1] = '{n: 4'd12, tens: 1, ones: 2, blank: 0};
    sweeps[2] = '{n: 4'd10, tens: 1, ones: 0, blank: 0};
    sweeps[3] = '{n: 4'd5,  tens: 0, ones: 5, blank: 1};

    // Reset.
    rst = 1'b1; button = 1'b1; num = 4'd0;
    step(3);
    rst = 1'b0;
    step(1);
    check("rst.phase", int'(phase), 0);
    check("rst.op_a", int'(op_a), 0);
    check("rst.op_b", int'(op_b), 0);
    check("rst.tens", int'(disp_tens), 0);
    check("rst.ones", int'(disp_ones), 0);
    check("rst.blank", int'(tens_blank), 1);
    check("rst.rv", int'(result_valid), 0);
    $display("[TB] reset released phase=%0d", phase);

    // Live display sweep in LOAD_A; op_a untouched.
    foreach (sweeps[i]) begin
      num = sweeps[i].n;
      step(4);
      check($sformatf("sweep%0d.tens", i), int'(disp_tens), sweeps[i].tens);
      check($sformatf("sweep%0d.ones", i), int'(disp_ones), sweeps[i].ones);
      check($sformatf("sweep%0d.blank", i), int'(tens_blank), sweeps[i].blank);
      check($sformatf("sweep%0d.op_a", i), int'(op_a), 0);
      $display("[TB] sweep num=%0d disp=%0d%0d blank=%0d", sweeps[i].n, disp_tens, disp_ones, tens_blank);
    end

    // Operand pairs from the vector table.
    foreach (vecs[i]) begin
      press(vecs[i].a, 1'b0, 14);
      check($sformatf("vec%0d.phaseA", i), int'(phase), 1);
      check($sformatf("vec%0d.op_a", i), int'(op_a), int'(vecs[i].a));
      press(vecs[i].b, 1'b0, 14);
      check_settle($sformatf("vec%0d", i));
      check($sformatf("vec%0d.op_b", i), int'(op_b), int'(vecs[i].b));
      check($sformatf("vec%0d.tens", i), int'(disp_tens), vecs[i].tens);
      check($sformatf("vec%0d.ones", i), int'(disp_ones), vecs[i].ones);
      check($sformatf("vec%0d.blank", i), int'(tens_blank), vecs[i].blank);
      check($sformatf("vec%0d.phase", i), int'(phase), 3);
      check($sformatf("vec%0d.rv", i), int'(result_valid), 1);
      press(4'd5, 1'b0, 14);
      check($sformatf("vec%0d.back_phase", i), int'(phase), 0);
      check($sformatf("vec%0d.back_rv", i), int'(result_valid), 0);
    end

    // Bouncing button, then held low for a long time: one advance only.
    press(4'd6, 1'b1, 110);
    check("bounce.advances", count_changes(), 1);
    check_all("bounce");

    // Randomized presses against the model.
    for (int it = 0; it < 24; it++) begin
      logic [3:0] v;
      bit bnc;
      v   = 4'($urandom_range(0, 15));
      bnc = 1'($urandom_range(0, 1));
      press(v, bnc, 14);
      if (m_phase == 3) check_settle($sformatf("rnd%0d", it));
      if (m_phase != 3) begin
        num = 4'($urandom_range(0, 15));
        step(4);
      end
      check_all($sformatf("rnd%0d", it));
    end

    // Reset while in SETTLE.
    for (int k = 0; k < 3 && m_phase != 0; k++) press(4'd1, 1'b0, 14);
    check("pre_rst.phase", int'(phase), 0);
    press(4'd8, 1'b0, 14);
    num = 4'd9;
    step(4);
    button = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1);
      if (phase == 2'd2) found = 1'b1;
    end
    check("rst_settle.reached", int'(found), 1);
    check("rst_settle.op_b", int'(op_b), 9);
    rst = 1'b1;
    button = 1'b1;
    step(1);
    check("rst_settle.phase", int'(phase), 0);
    check("rst_settle.op_a", int'(op_a), 0);
    check("rst_settle.op_b0", int'(op_b), 0);
    check("rst_settle.rv", int'(result_valid), 0);
    check("rst_settle.tens", int'(disp_tens), 0);
    check("rst_settle.ones", int'(disp_ones), 0);
    check("rst_settle.blank", int'(tens_blank), 1);
    step(2);
    rst = 1'b0;
    m_phase = 0; m_a = 0; m_b = 0; m_r = 0;
    step(20);
    check_all("post_rst");
    $display("[TB] reset in SETTLE -> phase=%0d disp=%0d%0d rv=%0d", phase, disp_tens, disp_ones, result_valid);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
